// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings,
// the allocation value and the counter step function.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = WNT;
  localparam ctr_e CTR_ALLOC = WT;

  // One step of the saturating counter toward taken (up) or not-taken.
  function automatic ctr_e ctr_step(input ctr_e cur, input logic up);
    ctr_e nxt;
    case (cur)
      SNT:     nxt = up ? WNT : SNT;
      WNT:     nxt = up ? WT  : SNT;
      WT:      nxt = up ? ST  : WNT;
      ST:      nxt = up ? ST  : WT;
      default: nxt = CTR_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating up/down counter with a load port; one per table entry.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_en,
  input  logic [1:0] load_val,
  input  logic       step_en,
  input  logic       up,
  output logic [1:0] ctr
);

  ctr_e ctr_r;

  // Counter state: load has priority over a step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_r <= CTR_RESET;
    end else if (load_en) begin
      ctr_r <= ctr_e'(load_val);
    end else if (step_en) begin
      ctr_r <= ctr_step(ctr_r, up);
    end else begin
      ctr_r <= ctr_r;
    end
  end

  assign ctr = ctr_r;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters and
// saturating update/mispredict statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              predict_hit,
  output logic              predict_taken,
  output logic [ADDR_W-1:0] predict_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispredict,
  input  logic              clear,
  output logic [CNT_W-1:0]  stat_updates,
  output logic [CNT_W-1:0]  stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W;

  logic [ENTRIES-1:0] valid_r;
  logic [TAG_W-1:0]   tag_r    [ENTRIES];
  logic [ADDR_W-1:0]  target_r [ENTRIES];
  logic [1:0]         entry_ctr_s [ENTRIES];
  logic [ENTRIES-1:0] ld_en_s;
  logic [ENTRIES-1:0] step_en_s;

  logic [IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic             lk_hit_s;
  logic [IDX_W-1:0] upd_idx_s;
  logic [TAG_W-1:0] upd_tag_s;
  logic             upd_hit_s;
  logic             upd_accept_s;
  logic             alloc_s;
  logic             train_s;

  logic [CNT_W-1:0] stat_updates_r;
  logic [CNT_W-1:0] stat_mispredicts_r;

  assign lk_idx_s  = lookup_pc[IDX_W-1:0];
  assign lk_tag_s  = lookup_pc[ADDR_W-1:IDX_W];
  assign upd_idx_s = upd_pc[IDX_W-1:0];
  assign upd_tag_s = upd_pc[ADDR_W-1:IDX_W];

  // Lookup reads current state only, so a same-cycle update shows up next cycle.
  always_comb begin
    lk_hit_s = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
    if (lk_hit_s) begin
      predict_hit    = 1'b1;
      predict_taken  = entry_ctr_s[lk_idx_s][1];
      predict_target = target_r[lk_idx_s];
    end else begin
      predict_hit    = 1'b0;
      predict_taken  = 1'b0;
      predict_target = lookup_pc + ADDR_W'(1);
    end
  end

  // Update classification; clear suppresses all table changes.
  always_comb begin
    upd_hit_s    = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
    upd_accept_s = upd_valid && !clear;
    if (upd_accept_s) begin
      alloc_s = !upd_hit_s && upd_taken;
      train_s = upd_hit_s;
    end else begin
      alloc_s = 1'b0;
      train_s = 1'b0;
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    assign ld_en_s[i]   = alloc_s && (upd_idx_s == IDX_W'(i));
    assign step_en_s[i] = train_s && (upd_idx_s == IDX_W'(i));

    bp_sat_counter u_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_en  (ld_en_s[i]),
      .load_val (CTR_ALLOC),
      .step_en  (step_en_s[i]),
      .up       (upd_taken),
      .ctr      (entry_ctr_s[i])
    );
  end

  // Valid bits: clear wins over allocation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
    end else if (clear) begin
      valid_r <= '0;
    end else if (alloc_s) begin
      valid_r[upd_idx_s] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag and target storage; a taken hit refreshes the target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tag_r[i]    <= '0;
        target_r[i] <= '0;
      end
    end else if (alloc_s) begin
      tag_r[upd_idx_s]    <= upd_tag_s;
      target_r[upd_idx_s] <= upd_target;
    end else if (train_s && upd_taken) begin
      target_r[upd_idx_s] <= upd_target;
    end else begin
      target_r[upd_idx_s] <= target_r[upd_idx_s];
    end
  end

  // Saturating statistics; these ignore clear on purpose.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_updates_r     <= '0;
      stat_mispredicts_r <= '0;
    end else begin
      if (upd_valid && (stat_updates_r != {CNT_W{1'b1}})) begin
        stat_updates_r <= stat_updates_r + CNT_W'(1);
      end
      if (upd_valid && upd_mispredict && (stat_mispredicts_r != {CNT_W{1'b1}})) begin
        stat_mispredicts_r <= stat_mispredicts_r + CNT_W'(1);
      end
    end
  end

  assign stat_updates     = stat_updates_r;
  assign stat_mispredicts = stat_mispredicts_r;

endmodule
